// File: rtl/exc_mem_pipe_pkg.sv
// Shared definitions for the M/W exception pipeline slice.
// Holds the load/store opcodes, the exception codes this stage raises,
// the pipeline FSM state encoding and a helper that decodes an opcode
// into memory-access attributes (is memory op, is load, access size).
package exc_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  typedef struct packed {
    logic       is_mem;
    logic       is_load;
    logic [2:0] size;
  } mem_op_t;

  // Map a primary opcode to its memory-access attributes.
  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d = '{is_mem: 1'b0, is_load: 1'b0, size: 3'd0};
    case (op)
      OP_LW:         d = '{is_mem: 1'b1, is_load: 1'b1, size: 3'd4};
      OP_LH, OP_LHU: d = '{is_mem: 1'b1, is_load: 1'b1, size: 3'd2};
      OP_LB, OP_LBU: d = '{is_mem: 1'b1, is_load: 1'b1, size: 3'd1};
      OP_SW:         d = '{is_mem: 1'b1, is_load: 1'b0, size: 3'd4};
      OP_SH:         d = '{is_mem: 1'b1, is_load: 1'b0, size: 3'd2};
      OP_SB:         d = '{is_mem: 1'b1, is_load: 1'b0, size: 3'd1};
      default:       d = '{is_mem: 1'b0, is_load: 1'b0, size: 3'd0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exc_mem_pipe_if.sv
// Bundle of the M-stage inputs, W-stage exception outputs and handshake
// between the pipeline (master) and the exception register (slave).
//   master: drives in_valid, instr_m, ao_m, ov_m, pc_m, exccode_e, bd_e,
//           stall, flush, exc_ack; receives the registered exception state.
//   slave : the reverse.
interface exc_mem_pipe_if;
  logic        in_valid;
  logic [31:0] instr_m;
  logic [31:0] ao_m;
  logic        ov_m;
  logic [31:0] pc_m;
  logic [4:0]  exccode_e;
  logic        bd_e;
  logic        stall;
  logic        flush;
  logic        exc_ack;
  logic [4:0]  exccode_w;
  logic        bd_w;
  logic [31:0] epc_w;
  logic [31:0] badvaddr_w;
  logic        exc_req;
  logic        busy;

  modport master (
    output in_valid, instr_m, ao_m, ov_m, pc_m, exccode_e, bd_e,
           stall, flush, exc_ack,
    input  exccode_w, bd_w, epc_w, badvaddr_w, exc_req, busy
  );

  modport slave (
    input  in_valid, instr_m, ao_m, ov_m, pc_m, exccode_e, bd_e,
           stall, flush, exc_ack,
    output exccode_w, bd_w, epc_w, badvaddr_w, exc_req, busy
  );
endinterface

// File: rtl/exc_addr_check.sv
// Combinational M-stage exception classifier.
// Ports: in_valid_i, op_i (primary opcode), ao_i (effective address),
// ov_i (address-add overflow), exccode_e_i (earlier-stage code);
// code_o (resulting exception code), badvaddr_o (faulting address or 0).
module exc_addr_check
  import exc_pkg::*;
#(
  parameter int                  N_DEV        = 2,
  parameter logic [31:0]         DM_TOP       = 32'h0000_2fff,
  parameter logic [N_DEV*32-1:0] DEV_BASE     = {32'h7f10, 32'h7f00},
  parameter logic [N_DEV*16-1:0] DEV_RD_BYTES = {16'd12, 16'd12},
  parameter logic [N_DEV*16-1:0] DEV_WR_BYTES = {16'd8, 16'd8}
) (
  input  logic        in_valid_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] ao_i,
  input  logic        ov_i,
  input  logic [4:0]  exccode_e_i,
  output logic [4:0]  code_o,
  output logic [31:0] badvaddr_o
);

  mem_op_t     dec_s;
  logic [32:0] ao33_s;
  logic [32:0] last_s;
  logic        dm_ok_s;
  logic        misal_s;
  logic        dev_hit_s;
  logic [32:0] base_s;
  logic [32:0] lim_s;

  assign dec_s  = decode_op(op_i);
  assign ao33_s = {1'b0, ao_i};
  // 33-bit sum so an access running past 32'hffff_ffff cannot wrap into range.
  assign last_s  = ao33_s + {30'd0, dec_s.size} - 33'd1;
  assign dm_ok_s = (last_s <= {1'b0, DM_TOP});

  // Alignment: words need ao[1:0]==0, halfwords ao[0]==0, bytes always fine.
  always_comb begin
    misal_s = 1'b0;
    case (dec_s.size)
      3'd4:    misal_s = (ao_i[1:0] != 2'b00);
      3'd2:    misal_s = ao_i[0];
      default: misal_s = 1'b0;
    endcase
  end

  // Device windows accept only full-word accesses; span depends on direction.
  always_comb begin
    dev_hit_s = 1'b0;
    base_s    = 33'd0;
    lim_s     = 33'd0;
    for (int i = 0; i < N_DEV; i++) begin
      base_s = {1'b0, DEV_BASE[32*i +: 32]};
      if (dec_s.is_load) begin
        lim_s = {17'd0, DEV_RD_BYTES[16*i +: 16]};
      end else begin
        lim_s = {17'd0, DEV_WR_BYTES[16*i +: 16]};
      end
      if ((dec_s.size == 3'd4) && (lim_s != 33'd0) &&
          (ao33_s >= base_s) && (ao33_s <= base_s + lim_s - 33'd1)) begin
        dev_hit_s = 1'b1;
      end else begin
        dev_hit_s = dev_hit_s;
      end
    end
  end

  // Priority: bubble, then earlier-stage code, then overflow/alignment/range.
  always_comb begin
    code_o     = EXC_NONE;
    badvaddr_o = 32'd0;
    if (!in_valid_i) begin
      code_o     = EXC_NONE;
      badvaddr_o = 32'd0;
    end else if (exccode_e_i != EXC_NONE) begin
      code_o     = exccode_e_i;
      badvaddr_o = 32'd0;
    end else if (dec_s.is_mem && (ov_i || misal_s || !(dm_ok_s || dev_hit_s))) begin
      code_o     = dec_s.is_load ? EXC_ADEL : EXC_ADES;
      badvaddr_o = ao_i;
    end else begin
      code_o     = EXC_NONE;
      badvaddr_o = 32'd0;
    end
  end

endmodule

// File: rtl/exc_mem_pipe.sv
// M/W pipeline register carrying exception state toward CP0.
// Ports: clk, reset (async, active-low), bus (exc_mem_pipe_if.slave):
//   inputs  in_valid, instr_m, ao_m, ov_m, pc_m, exccode_e, bd_e,
//           stall, flush, exc_ack
//   outputs exccode_w, bd_w, epc_w, badvaddr_w, exc_req, busy
// Once a nonzero code is captured the block parks in PEND, holding its
// outputs and back-pressuring upstream until CP0 acknowledges.
module exc_mem_pipe
  import exc_pkg::*;
#(
  parameter int                  N_DEV        = 2,
  parameter logic [31:0]         DM_TOP       = 32'h0000_2fff,
  parameter logic [N_DEV*32-1:0] DEV_BASE     = {32'h7f10, 32'h7f00},
  parameter logic [N_DEV*16-1:0] DEV_RD_BYTES = {16'd12, 16'd12},
  parameter logic [N_DEV*16-1:0] DEV_WR_BYTES = {16'd8, 16'd8}
) (
  input logic           clk,
  input logic           reset,
  exc_mem_pipe_if.slave bus
);

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bad_q, bad_d;

  logic [4:0]  chk_code_s;
  logic [31:0] chk_bad_s;
  logic        unused_instr_s;

  assign unused_instr_s = ^bus.instr_m[25:0];

  exc_addr_check #(
    .N_DEV        (N_DEV),
    .DM_TOP       (DM_TOP),
    .DEV_BASE     (DEV_BASE),
    .DEV_RD_BYTES (DEV_RD_BYTES),
    .DEV_WR_BYTES (DEV_WR_BYTES)
  ) u_check (
    .in_valid_i  (bus.in_valid),
    .op_i        (bus.instr_m[31:26]),
    .ao_i        (bus.ao_m),
    .ov_i        (bus.ov_m),
    .exccode_e_i (bus.exccode_e),
    .code_o      (chk_code_s),
    .badvaddr_o  (chk_bad_s)
  );

  // Next-state and next-register values; flush beats stall, PEND ignores both.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    bd_d    = bd_q;
    epc_d   = epc_q;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          code_d = EXC_NONE;
          bd_d   = 1'b0;
          epc_d  = 32'd0;
          bad_d  = 32'd0;
        end else if (bus.stall) begin
          state_d = ST_IDLE;
        end else if (bus.in_valid) begin
          code_d  = chk_code_s;
          bd_d    = bus.bd_e;
          epc_d   = bus.bd_e ? (bus.pc_m - 32'd4) : bus.pc_m;
          bad_d   = chk_bad_s;
          state_d = (chk_code_s != EXC_NONE) ? ST_PEND : ST_IDLE;
        end else begin
          // An empty M stage enters W as a bubble.
          code_d = EXC_NONE;
          bd_d   = 1'b0;
          epc_d  = 32'd0;
          bad_d  = 32'd0;
        end
      end
      ST_PEND: begin
        if (bus.exc_ack) begin
          code_d  = EXC_NONE;
          bd_d    = 1'b0;
          epc_d   = 32'd0;
          bad_d   = 32'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        code_d  = EXC_NONE;
        bd_d    = 1'b0;
        epc_d   = 32'd0;
        bad_d   = 32'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and M/W register; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      code_q  <= EXC_NONE;
      bd_q    <= 1'b0;
      epc_q   <= 32'd0;
      bad_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      epc_q   <= epc_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.exccode_w  = code_q;
  assign bus.bd_w       = bd_q;
  assign bus.epc_w      = epc_q;
  assign bus.badvaddr_w = bad_q;
  // Both flags decode the single state flop, so they cannot glitch.
  assign bus.exc_req    = (state_q == ST_PEND);
  assign bus.busy       = (state_q == ST_PEND);

endmodule

// File: doc/exc_mem_pipe.md
EXC_MEM_PIPE -- requirements
Module: exc_mem_pipe

Interface
REQ-001 SHALL have parameter N_DEV, default 2, number of memory-mapped device windows (1..8).
REQ-002 SHALL have parameter DM_TOP, default 32'h0000_2fff, last legal data-memory byte address; data memory spans 0..DM_TOP.
REQ-003 SHALL have parameter DEV_BASE, N_DEV*32 bits, default {32'h7f10,32'h7f00}, word-aligned base of each window; window i is bits [32i+31:32i].
REQ-004 SHALL have parameter DEV_RD_BYTES, N_DEV*16 bits, default {16'd12,16'd12}, readable span per window.
REQ-005 SHALL have parameter DEV_WR_BYTES, N_DEV*16 bits, default {16'd8,16'd8}, writable span per window.
REQ-006 Ports, name direction width meaning:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  M-stage holds a real instruction
instr_m  in  32  M-stage instruction
ao_m  in  32  effective address
ov_m  in  1  overflow in address add
pc_m  in  32  M-stage PC
exccode_e  in  5  exception code carried from earlier stages
bd_e  in  1  instruction sits in a branch delay slot
stall  in  1  hold the M/W register
flush  in  1  replace the next W entry with a bubble
exc_ack  in  1  CP0 has taken the exception
exccode_w  out  5  registered exception code
bd_w  out  1  registered delay-slot flag
epc_w  out  32  registered EPC
badvaddr_w  out  32  registered faulting address
exc_req  out  1  exception pending toward CP0
busy  out  1  back-pressure: upstream must stall

Function
REQ-007 SHALL decode loads lw/lh/lhu/lb/lbu as sizes 4/2/2/1/1 bytes and stores sw/sh/sb as sizes 4/2/1 bytes; all other opcodes are non-memory.
REQ-008 SHALL report exccode_e unchanged when it is nonzero; earlier-stage codes take priority over M-stage checks.
REQ-009 SHALL, for a memory op with exccode_e==0, raise AdEL (4) for loads or AdES (5) for stores on the first true condition: ov_m==1; misalignment (size 4 needs ao[1:0]==0, size 2 needs ao[0]==0); address illegal.
REQ-010 Address SHALL be legal when ao+size-1 <= DM_TOP, or when size==4 and ao lies in [DEV_BASE_i, DEV_BASE_i+LIM_i-1] for some i, where LIM is DEV_RD_BYTES for loads and DEV_WR_BYTES for stores.
REQ-011 Sub-word accesses to device windows SHALL be illegal.
REQ-012 Address arithmetic SHALL be 33-bit, so ao+size-1 wrapping past 32'hffff_ffff is illegal.
REQ-013 Non-memory ops and in_valid==0 SHALL yield exccode_e when in_valid==1, and 0 when in_valid==0.
REQ-014 epc_w SHALL equal pc_m-4 when bd_e==1, else pc_m; badvaddr_w SHALL equal ao_m for AdEL/AdES raised here, else 0.
REQ-015 FSM states SHALL be IDLE and PEND.
REQ-016 In IDLE, at each rising edge, the register SHALL: load a bubble (all outputs 0) if flush; else hold if stall; else capture. Flush SHALL override stall.
REQ-017 The FSM SHALL move IDLE->PEND on the edge that captures a nonzero code; exc_req SHALL then assert in the next cycle with one-cycle latency.
REQ-018 In PEND, exc_req and busy SHALL be 1, outputs SHALL hold, and stall/flush SHALL be ignored.
REQ-019 exc_ack in PEND SHALL clear the register to a bubble and move to IDLE on the same edge; exc_ack in IDLE SHALL be ignored.
REQ-020 exc_req and busy SHALL be registered-state decodes and glitch-free.

Reset
REQ-021 reset==0 SHALL asynchronously force IDLE and all outputs to 0, including during PEND.
REQ-022 The first edge after reset release SHALL behave as IDLE capture.

Structure
REQ-023 Opcodes, exception codes (NONE=0, ADEL=4, ADES=5) and the state enum SHALL live in shared package exc_pkg.
REQ-024 The combinational classifier (REQ-007..013) SHALL be sub-module exc_addr_check; exc_mem_pipe holds the register and FSM.

Verification
REQ-025 lw ao=32'h2ffc -> code 0; lw ao=32'h2ffe -> AdEL, badvaddr 32'h2ffe; lh ao=32'h2ffe -> 0; lh ao=32'h2fff -> AdEL.
REQ-026 Defaults: lw 32'h7f08 -> 0, sw 32'h7f08 -> AdES, sw 32'h7f14 -> 0, sb 32'h7f00 -> AdES, lw 32'h7f0c -> AdEL.
REQ-027 sw with ov_m=1 and aligned ao -> AdES; lw with exccode_e=10 and misaligned ao -> 10, badvaddr 0.
REQ-028 AdEL with bd_e=1, pc_m=32'h3008 -> epc_w 32'h3004; exc_req=1 next cycle; busy held 5 cycles with flush/stall toggled and outputs unchanged; exc_ack -> outputs 0, exc_req 0 next cycle.
REQ-029 Stall and flush both set in IDLE -> bubble; reset=0 asserted mid-PEND -> all outputs 0 immediately, without waiting for a clock edge.
REQ-030 N_DEV=1, DEV_BASE=32'h8000, RD=4, WR=4: lw 32'h8000 -> 0, lw 32'h8004 -> AdEL.
